w_input_conditioner: RTL and testbench
======================================

// Module: w_input_conditioner
// PURPOSE
//  - Upstream stage of the W-sequence detector FSM.
//  - Takes the raw, asynchronous board switch/button level and synchronises it into
//    sys_clock, then debounces it.
//  - Drives a clean single-clock-domain level w_out, which feeds the detector's W
//    input, plus one-cycle edge strobes for status LEDs and counters.
//  - Without this stage, switch bounce produces spurious 4-in-a-row detections
//    downstream.
// PARAMETERS
//  SYNC_STAGES      2   flip-flops in synchroniser chain; legal >= 2
//  DEBOUNCE_CYCLES  16  consecutive stable cycles required before w_out follows input; legal >= 1
//  CNT_W            $clog2(DEBOUNCE_CYCLES+1)  debounce counter width (derived, localparam)
// PORTS
//  sys_clock  in   1      system clock; all state on rising edge
//  sys_reset  in   1      asynchronous active-low reset
//  raw_in     in   1      raw switch level, asynchronous to sys_clock
//  w_out      out  1      debounced, synchronised level (drives detector W)
//  w_rise     out  1      one-cycle pulse, same edge w_out goes 0->1
//  w_fall     out  1      one-cycle pulse, same edge w_out goes 1->0
//  busy       out  1      high while debounce counter is non-zero (candidate change pending)
// BEHAVIOUR
//  Reset (sys_reset low, async):
//  - sync chain, w_out, w_rise, w_fall, busy and counter all 0.
//  - Takes effect immediately, regardless of clock.
//  - Release is synchronous in effect: the first active edge after release does normal work.
//  Synchroniser:
//  - sync[0] <= raw_in; sync[i] <= sync[i-1].
//  - s = sync[SYNC_STAGES-1].
//  - No logic between stages.
//  Debounce (counter cnt, CNT_W bits):
//  - s == w_out: cnt <= 0; outputs hold.
//  - s != w_out and cnt <  DEBOUNCE_CYCLES-1: cnt <= cnt+1.
//  - s != w_out and cnt == DEBOUNCE_CYCLES-1: w_out <= s, cnt <= 0.
//    At that same edge, w_rise <= s or w_fall <= ~s.
//  - Any single cycle with s == w_out during counting restarts the count from 0
//    (glitch rejection).
//  - cnt never exceeds DEBOUNCE_CYCLES-1; no wrap-around.
//  Edge strobes:
//  - w_rise and w_fall are registered.
//  - Each is high exactly one cycle, and they are never high together.
//  - They are 0 on every cycle w_out does not change.
//  busy:
//  - Registered; equals (cnt != 0) after each edge.
//  DEBOUNCE_CYCLES == 1:
//  - w_out follows s on the first mismatch edge; busy stays 0.
//  Latency:
//  - raw step captured at edge 1 into sync[0].
//  - w_out changes at edge SYNC_STAGES+DEBOUNCE_CYCLES (defaults: edge 18).
//  - The step must be held stable throughout.
//  Minimum pulse:
//  - raw pulses shorter than DEBOUNCE_CYCLES cycles (after sync) never reach w_out.
//  Reset mid-count:
//  - Counter is discarded and w_out returns to 0.
//  - If raw_in is still 1 after release, a full SYNC_STAGES+DEBOUNCE_CYCLES latency
//    applies again.
//  Inference:
//  - No latches; only reset-controlled flops.
//  - Outputs are driven from flops only; no combinational path raw_in->outputs.
// TESTING (defaults unless stated)
//  1. Hold sys_reset low, toggle raw_in and sys_clock
//     -> w_out=w_rise=w_fall=busy=0 throughout.
//  2. Release reset, raw_in 0->1 held
//     -> w_out=1 at edge 18, w_rise=1 on that cycle only, busy high edges 3..17.
//     Then raw_in 1->0 held -> w_fall single pulse at the matching edge.
//  3. raw_in high for 10 cycles then low
//     -> w_out stays 0, no strobes, busy returns to 0 within 3 cycles after s drops.
//  4. Bounce: raw_in 1,0,1,0,1 (1 cycle each) then stable 1
//     -> exactly one w_rise, at 18 edges after the final 0->1.
//  5. raw_in stable 1, assert sys_reset mid-count (cnt=8) then release
//     -> w_out=0 immediately; w_rise 18 edges after release.
//  6. DEBOUNCE_CYCLES=1, SYNC_STAGES=3, raw_in step
//     -> w_out changes at edge 4, busy never asserted.

Source files
------------

// File: rtl/w_input_conditioner.sv
// Synchroniser + debouncer for the raw W switch level feeding the sequence detector.
// Produces a clean level plus registered one-cycle rise/fall strobes and a busy flag.
module w_input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic sys_clock,
  input  logic sys_reset,
  input  logic raw_in,
  output logic w_out,
  output logic w_rise,
  output logic w_fall,
  output logic busy
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_w_out;
  logic                   r_w_rise;
  logic                   r_w_fall;
  logic                   r_busy;

  logic                   w_s;
  logic                   w_mismatch;
  logic                   w_commit;
  logic [CNT_W-1:0]       w_cnt_next;

  assign w_s        = r_sync[SYNC_STAGES-1];
  assign w_mismatch = (w_s != r_w_out);
  assign w_commit   = w_mismatch && (r_cnt == CNT_LAST);

  // Count resets on any agreement cycle, so a single-cycle glitch restarts the window.
  always_comb begin
    w_cnt_next = '0;
    if (w_mismatch && !w_commit) begin
      w_cnt_next = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge sys_clock or negedge sys_reset) begin
    if (!sys_reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], raw_in};
    end
  end

  always_ff @(posedge sys_clock or negedge sys_reset) begin
    if (!sys_reset) begin
      r_cnt    <= '0;
      r_w_out  <= 1'b0;
      r_w_rise <= 1'b0;
      r_w_fall <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_next;
      r_busy   <= (w_cnt_next != '0);
      r_w_rise <= w_commit & w_s;
      r_w_fall <= w_commit & ~w_s;
      if (w_commit) begin
        r_w_out <= w_s;
      end
    end
  end

  assign w_out  = r_w_out;
  assign w_rise = r_w_rise;
  assign w_fall = r_w_fall;
  assign busy   = r_busy;

endmodule

// File: tb/tb_w_input_conditioner.sv
// Directed bench for w_input_conditioner: default instance plus a fast
// (SYNC_STAGES=3, DEBOUNCE_CYCLES=1) instance; outputs packed as {w_out,w_rise,w_fall,busy}.
module tb_w_input_conditioner;

  logic sys_clock = 1'b0;
  logic sys_reset = 1'b0;
  logic raw_in    = 1'b0;
  logic w_out, w_rise, w_fall, busy;

  logic rst6 = 1'b0;
  logic raw6 = 1'b0;
  logic f_out, f_rise, f_fall, f_busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 sys_clock = ~sys_clock;

  w_input_conditioner #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(16)
  ) u_dut (
    .sys_clock(sys_clock),
    .sys_reset(sys_reset),
    .raw_in   (raw_in),
    .w_out    (w_out),
    .w_rise   (w_rise),
    .w_fall   (w_fall),
    .busy     (busy)
  );

  w_input_conditioner #(
    .SYNC_STAGES    (3),
    .DEBOUNCE_CYCLES(1)
  ) u_fast (
    .sys_clock(sys_clock),
    .sys_reset(rst6),
    .raw_in   (raw6),
    .w_out    (f_out),
    .w_rise   (f_rise),
    .w_fall   (f_fall),
    .busy     (f_busy)
  );

  typedef struct {
    logic        rst_n;
    logic        raw;
    int unsigned edges;
    logic [3:0]  exp;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge sys_clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (w_out,w_rise,w_fall,busy)", name, got, exp);
    end
  endtask

  function automatic logic [3:0] main_o();
    return {w_out, w_rise, w_fall, busy};
  endfunction

  function automatic logic [3:0] fast_o();
    return {f_out, f_rise, f_fall, f_busy};
  endfunction

  // Clean 0->1 step from idle: busy on edges 3..17, commit on edge 18.
  function automatic logic [3:0] step_rise_exp(input int e);
    return {e >= 18, e == 18, 1'b0, (e >= 3 && e <= 17)};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int pat[5];

    vecs[0] = '{1'b0, 1'b0, 3, 4'b0000};
    vecs[1] = '{1'b0, 1'b1, 3, 4'b0000};
    vecs[2] = '{1'b0, 1'b0, 1, 4'b0000};
    vecs[3] = '{1'b0, 1'b1, 2, 4'b0000};
    vecs[4] = '{1'b1, 1'b0, 4, 4'b0000};
    vecs[5] = '{1'b1, 1'b1, 2, 4'b0000};
    vecs[6] = '{1'b1, 1'b1, 1, 4'b0001};
    vecs[7] = '{1'b1, 1'b0, 2, 4'b0001};
    vecs[8] = '{1'b1, 1'b0, 1, 4'b0000};
    vecs[9] = '{1'b1, 1'b0, 3, 4'b0000};

    #1;
    chk("reset_initial", main_o(), 4'b0000);

    // Reset hold with raw toggling, then a short pulse that must not reach w_out.
    for (int v = 0; v < 10; v++) begin
      sys_reset = vecs[v].rst_n;
      raw_in    = vecs[v].raw;
      for (int unsigned k = 0; k < vecs[v].edges; k++) begin
        tick();
        chk($sformatf("vec%0d_edge%0d", v, k), main_o(), vecs[v].exp);
      end
    end

    raw_in = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      chk($sformatf("step_rise_e%0d", e), main_o(), step_rise_exp(e));
    end
    raw_in = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      chk($sformatf("step_fall_e%0d", e), main_o(),
          {e < 18, 1'b0, e == 18, (e >= 3 && e <= 17)});
    end

    // 10-cycle pulse: counts 1..10 on edges 3..12, drops back on edge 13.
    raw_in = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      tick();
      if (e == 10) raw_in = 1'b0;
      chk($sformatf("short_pulse_e%0d", e), main_o(), {3'b000, (e >= 3 && e <= 12)});
    end

    // Bounce 1,0,1,0,1 then stable 1: final 0->1 captured at edge 5, commit at edge 22.
    pat = '{1, 0, 1, 0, 1};
    for (int e = 1; e <= 26; e++) begin
      if (e <= 5) raw_in = pat[e-1][0];
      tick();
      chk($sformatf("bounce_e%0d", e), main_o(),
          {e >= 22, e == 22, 1'b0, (e == 3 || e == 5 || (e >= 7 && e <= 21))});
    end

    sys_reset = 1'b0;
    #1;
    chk("async_reset_clears_w_out", main_o(), 4'b0000);
    tick();
    chk("reset_hold_raw1", main_o(), 4'b0000);
    sys_reset = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      chk($sformatf("precount_e%0d", e), main_o(), {3'b000, e >= 3});
    end
    sys_reset = 1'b0;
    #1;
    chk("async_reset_mid_count", main_o(), 4'b0000);
    tick();
    sys_reset = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      chk($sformatf("after_reset_e%0d", e), main_o(), step_rise_exp(e));
    end

    chk("fast_in_reset", fast_o(), 4'b0000);
    rst6 = 1'b1;
    raw6 = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk($sformatf("fast_rise_e%0d", e), fast_o(), {e >= 4, e == 4, 2'b00});
    end
    raw6 = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      chk($sformatf("fast_fall_e%0d", e), fast_o(), {e < 4, 1'b0, e == 4, 1'b0});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
